// File: rtl/wb_mem_pipe_if.sv
// Pipelined Wishbone bus bundle between a master and the wb_mem_pipe slave.
// Signal names keep the slave-side _i/_o suffixes so the slave port list reads as the bus definition.
interface wb_mem_pipe_if #(
    parameter int G_ADDR_SIZE = 8,
    parameter int G_DATA_SIZE = 16
);
    logic                       wb_cyc_i;
    logic                       wb_stall_o;
    logic                       wb_stb_i;
    logic                       wb_ack_o;
    logic                       wb_err_o;
    logic                       wb_we_i;
    logic [G_ADDR_SIZE-1:0]     wb_addr_i;
    logic [G_DATA_SIZE/8-1:0]   wb_sel_i;
    logic [G_DATA_SIZE-1:0]     wb_data_i;
    logic [G_DATA_SIZE-1:0]     wb_data_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        output wb_stall_o, wb_ack_o, wb_err_o, wb_data_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i,
        input  wb_stall_o, wb_ack_o, wb_err_o, wb_data_o
    );
endinterface

// File: rtl/wb_mem_pipe.sv
// Pipelined Wishbone slave RAM: fixed G_LATENCY response delay, G_DEPTH words, ERR beyond depth.
// Optional macro WB_MEM_PIPE_SEL_EN enables byte-lane write masking via wb_sel_i.
module wb_mem_pipe #(
    parameter int G_ADDR_SIZE = 8,
    parameter int G_DATA_SIZE = 16,
    parameter int G_DEPTH     = 2**G_ADDR_SIZE,
    parameter int G_LATENCY   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_mem_pipe_if.slave    wb
);
    localparam int NB = G_DATA_SIZE / 8;
    localparam logic [G_ADDR_SIZE:0] DEPTH_W = (G_ADDR_SIZE+1)'(G_DEPTH);

    logic                   accept;
    logic                   in_range;
    logic [G_DATA_SIZE-1:0] rd_word;

    logic [G_DATA_SIZE-1:0] mem_q [G_DEPTH];

    logic [G_LATENCY-1:0]   ack_q, ack_d;
    logic [G_LATENCY-1:0]   err_q, err_d;
    logic [G_DATA_SIZE-1:0] data_q [G_LATENCY];
    logic [G_DATA_SIZE-1:0] data_d [G_LATENCY];

    // Handshake: a request is taken on any rising edge where cyc & stb are high and stall is low;
    // each taken request yields exactly one ack or err pulse G_LATENCY cycles later, in order.
    assign wb.wb_stall_o = rst_i;
    assign accept        = wb.wb_cyc_i & wb.wb_stb_i & ~rst_i;
    assign in_range      = {1'b0, wb.wb_addr_i} < DEPTH_W;

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_q[wb.wb_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && in_range && wb.wb_we_i) begin
`ifdef WB_MEM_PIPE_SEL_EN
            for (int b = 0; b < NB; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem_q[wb.wb_addr_i][b*8 +: 8] <= wb.wb_data_i[b*8 +: 8];
                end
            end
`else
            mem_q[wb.wb_addr_i] <= wb.wb_data_i;
`endif
        end
    end

    // Dropping cyc flushes every in-flight response; reset does the same in the register process.
    always_comb begin
        ack_d = '0;
        err_d = '0;
        for (int i = 0; i < G_LATENCY; i++) begin
            data_d[i] = '0;
        end
        if (wb.wb_cyc_i) begin
            ack_d[0]  = accept & in_range;
            err_d[0]  = accept & ~in_range;
            data_d[0] = (accept && in_range && !wb.wb_we_i) ? rd_word : '0;
            for (int i = 1; i < G_LATENCY; i++) begin
                ack_d[i]  = ack_q[i-1];
                err_d[i]  = err_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= '0;
            err_q <= '0;
            for (int i = 0; i < G_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            for (int i = 0; i < G_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign wb.wb_ack_o  = ack_q[G_LATENCY-1];
    assign wb.wb_err_o  = err_q[G_LATENCY-1];
    assign wb.wb_data_o = data_q[G_LATENCY-1];
endmodule

// File: tb/tb_wb_mem_pipe.sv
// Directed-vector bench for wb_mem_pipe: a latency-3/depth-200 instance and a latency-2/full-depth instance.
module tb_wb_mem_pipe;
  typedef struct {
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  sel;
    logic [15:0] wdat;
    logic        e_ack;
    logic        e_err;
    logic [15:0] e_dat;
  } vec_t;

`ifdef WB_MEM_PIPE_SEL_EN
  localparam logic [15:0] SEL_RES = 16'h12CD;
`else
  localparam logic [15:0] SEL_RES = 16'hABCD;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a;
  logic rst_b;

  wb_mem_pipe_if #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16)) bus_a ();
  wb_mem_pipe_if #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16)) bus_b ();

  wb_mem_pipe #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_DEPTH(200), .G_LATENCY(3)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .wb(bus_a)
  );
  wb_mem_pipe #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_DEPTH(256), .G_LATENCY(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .wb(bus_b)
  );

  int total = 0;
  int bad = 0;
  vec_t ta[$];
  vec_t tb_q[$];

  function automatic vec_t mk(bit r, bit c, bit s, bit w, logic [7:0] a, logic [1:0] sl,
                              logic [15:0] d, bit ea, bit ee, logic [15:0] ed);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.addr = a; v.sel = sl; v.wdat = d;
    v.e_ack = ea; v.e_err = ee; v.e_dat = ed;
    return v;
  endfunction

  function automatic vec_t rd(logic [7:0] a, bit ea, bit ee, logic [15:0] ed);
    return mk(0, 1, 1, 0, a, 2'b11, 16'h0, ea, ee, ed);
  endfunction
  function automatic vec_t wr(logic [7:0] a, logic [1:0] sl, logic [15:0] d, bit ea, bit ee, logic [15:0] ed);
    return mk(0, 1, 1, 1, a, sl, d, ea, ee, ed);
  endfunction
  function automatic vec_t idle(bit ea, bit ee, logic [15:0] ed);
    return mk(0, 1, 0, 0, 8'h00, 2'b11, 16'h0, ea, ee, ed);
  endfunction
  function automatic vec_t abt();
    return mk(0, 0, 0, 0, 8'h00, 2'b11, 16'h0, 0, 0, 16'h0);
  endfunction

  // scoreboard compare
  task automatic check(string name, int row, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // driver: apply one vector for one cycle, then check outputs half a cycle after the edge
  task automatic step(int which, int row, vec_t v);
    if (which == 0) begin
      rst_a = v.rst; bus_a.wb_cyc_i = v.cyc; bus_a.wb_stb_i = v.stb; bus_a.wb_we_i = v.we;
      bus_a.wb_addr_i = v.addr; bus_a.wb_sel_i = v.sel; bus_a.wb_data_i = v.wdat;
    end else begin
      rst_b = v.rst; bus_b.wb_cyc_i = v.cyc; bus_b.wb_stb_i = v.stb; bus_b.wb_we_i = v.we;
      bus_b.wb_addr_i = v.addr; bus_b.wb_sel_i = v.sel; bus_b.wb_data_i = v.wdat;
    end
    @(posedge clk);
    @(negedge clk);
    if (which == 0) begin
      check("a_stall", row, {15'h0, bus_a.wb_stall_o}, {15'h0, v.rst});
      check("a_ack",   row, {15'h0, bus_a.wb_ack_o},   {15'h0, v.e_ack});
      check("a_err",   row, {15'h0, bus_a.wb_err_o},   {15'h0, v.e_err});
      check("a_data",  row, bus_a.wb_data_o, v.e_dat);
    end else begin
      check("b_stall", row, {15'h0, bus_b.wb_stall_o}, {15'h0, v.rst});
      check("b_ack",   row, {15'h0, bus_b.wb_ack_o},   {15'h0, v.e_ack});
      check("b_err",   row, {15'h0, bus_b.wb_err_o},   {15'h0, v.e_err});
      check("b_data",  row, bus_b.wb_data_o, v.e_dat);
    end
  endtask

  initial begin
    rst_a = 1'b1; bus_a.wb_cyc_i = 0; bus_a.wb_stb_i = 0; bus_a.wb_we_i = 0;
    bus_a.wb_addr_i = 0; bus_a.wb_sel_i = 0; bus_a.wb_data_i = 0;
    rst_b = 1'b1; bus_b.wb_cyc_i = 0; bus_b.wb_stb_i = 0; bus_b.wb_we_i = 0;
    bus_b.wb_addr_i = 0; bus_b.wb_sel_i = 0; bus_b.wb_data_i = 0;

    // Instance A, latency 3: row r shows the response of the request in row r-2.
    ta.push_back(mk(1, 0, 0, 0, 8'h00, 2'b11, 16'h0, 0, 0, 16'h0));  // 0 reset
    ta.push_back(abt());                                             // 1
    ta.push_back(wr(8'h10, 2'b11, 16'hA5A5, 0, 0, 16'h0));          // 2
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 3
    ta.push_back(wr(8'hC7, 2'b11, 16'h5A5A, 1, 0, 16'h0));          // 4 ack write@2
    ta.push_back(rd(8'hC8, 1, 0, 16'hA5A5));                         // 5 ack read@3
    ta.push_back(wr(8'hC8, 2'b11, 16'hFFFF, 1, 0, 16'h0));          // 6 ack write@4
    ta.push_back(rd(8'hC7, 0, 1, 16'h0));                            // 7 err read C8
    ta.push_back(rd(8'hFF, 0, 1, 16'h0));                            // 8 err write C8
    ta.push_back(wr(8'h20, 2'b11, 16'h1234, 1, 0, 16'h5A5A));       // 9 C7 kept
    ta.push_back(wr(8'h20, 2'b01, 16'hABCD, 0, 1, 16'h0));          // 10 err read FF
    ta.push_back(rd(8'h20, 1, 0, 16'h0));                            // 11
    ta.push_back(idle(1, 0, 16'h0));                                 // 12
    ta.push_back(idle(1, 0, SEL_RES));                               // 13 byte-lane result
    ta.push_back(idle(0, 0, 16'h0));                                 // 14
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 15
    ta.push_back(rd(8'hC7, 0, 0, 16'h0));                            // 16
    ta.push_back(rd(8'h10, 1, 0, 16'hA5A5));                         // 17
    ta.push_back(idle(1, 0, 16'h5A5A));                              // 18
    ta.push_back(abt());                                             // 19 flushes read@17
    ta.push_back(idle(0, 0, 16'h0));                                 // 20
    ta.push_back(idle(0, 0, 16'h0));                                 // 21
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 22
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 23
    ta.push_back(rd(8'h10, 1, 0, 16'hA5A5));                         // 24
    ta.push_back(abt());                                             // 25 flushes 23,24
    ta.push_back(idle(0, 0, 16'h0));                                 // 26
    ta.push_back(idle(0, 0, 16'h0));                                 // 27
    ta.push_back(rd(8'h20, 0, 0, 16'h0));                            // 28 new cycle
    ta.push_back(idle(0, 0, 16'h0));                                 // 29
    ta.push_back(idle(1, 0, SEL_RES));                               // 30
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 31
    ta.push_back(rd(8'hC7, 0, 0, 16'h0));                            // 32
    ta.push_back(mk(1, 1, 1, 0, 8'h10, 2'b11, 16'h0, 0, 0, 16'h0));  // 33 reset mid-flight
    ta.push_back(idle(0, 0, 16'h0));                                 // 34
    ta.push_back(idle(0, 0, 16'h0));                                 // 35
    ta.push_back(idle(0, 0, 16'h0));                                 // 36
    ta.push_back(mk(0, 0, 1, 1, 8'h10, 2'b11, 16'h0000, 0, 0, 16'h0)); // 37 stb without cyc
    ta.push_back(idle(0, 0, 16'h0));                                 // 38
    ta.push_back(idle(0, 0, 16'h0));                                 // 39
    ta.push_back(rd(8'h10, 0, 0, 16'h0));                            // 40
    ta.push_back(idle(0, 0, 16'h0));                                 // 41
    ta.push_back(idle(1, 0, 16'hA5A5));                              // 42 write@37 ignored

    // Instance B, latency 2: row r shows the response of the request in row r-1.
    tb_q.push_back(mk(1, 0, 0, 0, 8'h00, 2'b11, 16'h0, 0, 0, 16'h0)); // 0 reset
    tb_q.push_back(wr(8'h01, 2'b11, 16'h0011, 0, 0, 16'h0));         // 1
    tb_q.push_back(wr(8'h02, 2'b11, 16'h0022, 1, 0, 16'h0));         // 2
    tb_q.push_back(wr(8'h03, 2'b11, 16'h0033, 1, 0, 16'h0));         // 3
    tb_q.push_back(wr(8'h04, 2'b11, 16'h0044, 1, 0, 16'h0));         // 4
    tb_q.push_back(rd(8'h01, 1, 0, 16'h0));                           // 5
    tb_q.push_back(rd(8'h02, 1, 0, 16'h0011));                        // 6
    tb_q.push_back(rd(8'h03, 1, 0, 16'h0022));                        // 7
    tb_q.push_back(rd(8'h04, 1, 0, 16'h0033));                        // 8
    tb_q.push_back(idle(1, 0, 16'h0044));                             // 9
    tb_q.push_back(idle(0, 0, 16'h0));                                // 10
    tb_q.push_back(rd(8'h01, 0, 0, 16'h0));                           // 11
    tb_q.push_back(abt());                                            // 12 flushes read@11
    tb_q.push_back(idle(0, 0, 16'h0));                                // 13
    tb_q.push_back(wr(8'hFF, 2'b11, 16'h00EE, 0, 0, 16'h0));         // 14 top word in range
    tb_q.push_back(rd(8'hFF, 1, 0, 16'h0));                           // 15
    tb_q.push_back(idle(1, 0, 16'h00EE));                             // 16
    tb_q.push_back(idle(0, 0, 16'h0));                                // 17

    @(negedge clk);
    for (int i = 0; i < ta.size(); i++) begin
      step(0, i, ta[i]);
    end
    for (int i = 0; i < tb_q.size(); i++) begin
      step(1, i, tb_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
